// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Function : multicycle control FSM with a shared ALU/memory port, memory
//            ready stall handling and a sticky bus-timeout flag.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_controller #(
    parameter int OP_W        = 4,
    parameter int FUNCT_W     = 6,
    parameter int ALU_W       = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcWrite,
    output logic               irWrite,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               regWrite,
    output logic [1:0]         regDst,
    output logic [1:0]         memToReg,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [ALU_W-1:0]   aluCtrl,
    output logic [1:0]         pcSrc,
    output logic [3:0]         state,
    output logic               instr_done,
    output logic               illegal,
    output logic               halted,
    output logic               bus_err
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [OP_W-1:0]  c_OP_R    = OP_W'(0);
    localparam logic [OP_W-1:0]  c_OP_ADDI = OP_W'(1);
    localparam logic [OP_W-1:0]  c_OP_LW   = OP_W'(2);
    localparam logic [OP_W-1:0]  c_OP_SW   = OP_W'(3);
    localparam logic [OP_W-1:0]  c_OP_BEQ  = OP_W'(4);
    localparam logic [OP_W-1:0]  c_OP_BNE  = OP_W'(5);
    localparam logic [OP_W-1:0]  c_OP_J    = OP_W'(6);
    localparam logic [OP_W-1:0]  c_OP_JAL  = OP_W'(7);
    localparam logic [OP_W-1:0]  c_OP_HALT = OP_W'(15);
    localparam logic [ALU_W-1:0] c_ALU_ADD = ALU_W'(3'b010);
    localparam logic [ALU_W-1:0] c_ALU_SUB = ALU_W'(3'b110);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_ALUWB  = 4'd7,
        S_EXEC_I = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;

    logic w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_bne;
    logic w_is_j, w_is_jal, w_is_halt, w_legal;
    logic w_wait_state, w_timeout;
    logic w_unused_funct;

    assign w_is_r    = (op == c_OP_R);
    assign w_is_addi = (op == c_OP_ADDI);
    assign w_is_lw   = (op == c_OP_LW);
    assign w_is_sw   = (op == c_OP_SW);
    assign w_is_beq  = (op == c_OP_BEQ);
    assign w_is_bne  = (op == c_OP_BNE);
    assign w_is_j    = (op == c_OP_J);
    assign w_is_jal  = (op == c_OP_JAL);
    assign w_is_halt = (op == c_OP_HALT);
    assign w_legal   = w_is_r | w_is_addi | w_is_lw | w_is_sw | w_is_beq |
                       w_is_bne | w_is_j | w_is_jal | w_is_halt;

    assign w_unused_funct = ^funct;

    // Only the three memory-access states can stall on mem_ready.
    assign w_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                          (state_q == S_MEMWR);
    assign w_timeout    = w_wait_state && !mem_ready && (cnt_q == c_CNT_MAX);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (w_is_r)                   state_d = S_EXEC_R;
                else if (w_is_addi)           state_d = S_EXEC_I;
                else if (w_is_lw || w_is_sw)  state_d = S_MEMADR;
                else if (w_is_beq || w_is_bne) state_d = S_BRANCH;
                else if (w_is_j || w_is_jal)  state_d = S_JUMP;
                else if (w_is_halt)           state_d = S_HALT;
                else                          state_d = S_FETCH;
            end
            S_MEMADR: state_d = w_is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC_R: state_d = S_ALUWB;
            S_EXEC_I: state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        if (w_timeout) state_d = S_HALT;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_timeout) bus_err_q <= 1'b1;
            if (w_wait_state && !mem_ready && !w_timeout) cnt_q <= cnt_q + 1'b1;
            else                                          cnt_q <= '0;
        end
    end

    always_comb begin
        pcWrite    = 1'b0;
        irWrite    = 1'b0;
        iorD       = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        regWrite   = 1'b0;
        regDst     = 2'b00;
        memToReg   = 2'b00;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        aluCtrl    = '0;
        pcSrc      = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                aluCtrl = c_ALU_ADD;
                pcWrite = mem_ready;
                irWrite = mem_ready;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                aluCtrl = c_ALU_ADD;
                illegal = ~w_legal;
            end
            S_MEMADR, S_EXEC_I: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluCtrl = c_ALU_ADD;
            end
            S_MEMRD: begin
                iorD    = 1'b1;
                memRead = 1'b1;
            end
            S_MEMWB: begin
                regWrite   = 1'b1;
                memToReg   = 2'b01;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iorD       = 1'b1;
                memWrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC_R: begin
                aluSrcA = 1'b1;
                aluCtrl = funct[ALU_W-1:0];
            end
            S_ALUWB: begin
                regWrite   = 1'b1;
                regDst     = w_is_r ? 2'b01 : 2'b00;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA    = 1'b1;
                aluCtrl    = c_ALU_SUB;
                pcSrc      = 2'b01;
                pcWrite    = w_is_beq ? zero : ~zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pcSrc      = 2'b10;
                pcWrite    = 1'b1;
                instr_done = 1'b1;
                if (w_is_jal) begin
                    regWrite = 1'b1;
                    regDst   = 2'b10;
                    memToReg = 2'b10;
                end
            end
            default: ;
        endcase
        // Reset must abort the current instruction with no side effects.
        if (!reset) begin
            pcWrite    = 1'b0;
            irWrite    = 1'b0;
            memRead    = 1'b0;
            memWrite   = 1'b0;
            regWrite   = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign bus_err = bus_err_q;

endmodule
`default_nettype wire
